tage_tagged_table_v2: RTL and testbench
=======================================

Name: tage_tagged_table_v2

Overview:
- Parametrised tagged TAGE component table; successor to the fixed two-slot table used by the TAGE predictor.
- Generalised in slot count, depth and field widths. Adds per-entry valid bits and a hardware init sweep with a ready flag.
- Adds tick-driven useful-bit aging via a background sweep FSM.
- Sits under the TAGE top; one instance per history bank.

Parameters:
- SLOT_NUM, 2: branch slots per entry (per fetch block).
- DEPTH, 2048: entries per slot; power of two.
- ADDR_WIDTH, $clog2(DEPTH): index width (derived).
- TAG_WIDTH, 8: tag bits.
- CTR_WIDTH, 3: prediction counter bits, unsigned saturating.
- U_WIDTH, 2: useful counter bits, unsigned saturating.
- TICK_WIDTH, 7: allocation-failure tick counter bits.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- lookup_en  in  1  sample lookup_idx/lookup_tag this cycle
- lookup_idx  in  ADDR_WIDTH  lookup set
- lookup_tag  in  TAG_WIDTH  lookup tag
- lookup_match  out  SLOT_NUM  valid & tag hit, per slot
- lookup_ctr  out  SLOT_NUM*CTR_WIDTH  stored counters
- lookup_u  out  SLOT_NUM*U_WIDTH  stored useful counters
- taken  out  SLOT_NUM  MSB of each lookup_ctr
- update_idx  in  ADDR_WIDTH  update set
- update_tag  in  TAG_WIDTH  update tag
- update_en  in  SLOT_NUM  slot update valid
- provider  in  SLOT_NUM  slot was provider
- alloc  in  SLOT_NUM  allocate slot
- real_taken  in  SLOT_NUM  resolved direction
- origin_ctr  in  SLOT_NUM*CTR_WIDTH  counter from prediction meta
- update_u_en  in  SLOT_NUM  write useful counter
- update_u  in  SLOT_NUM*U_WIDTH  new useful value
- alloc_fail  in  1  global allocation found no u==0 candidate
- alloc_ok  in  1  global allocation succeeded
- ready  out  1  table initialised
- aging_busy  out  1  aging sweep in progress

Behaviour:
- Entry per slot: {valid, tag, ctr, u}. The u array is flop-based; the {valid, tag, ctr} array may map to RAM with 1R1W.
- FSM states: INIT, IDLE, AGING.
- INIT:
  - Entered on rst from any state, including mid-sweep.
  - Clears valid, ctr and u of entry ptr per cycle, ptr 0..DEPTH-1.
  - Moves to IDLE after ptr==DEPTH-1; ready goes 1 on the following cycle.
  - Updates are ignored; lookup_match is forced to 0.
- Reset values: ready=0, aging_busy=0, lookup_match=0, lookup_ctr=0, lookup_u=0, taken=0, tick=0, ptr=0.
- Lookup:
  - 1-cycle latency: sample at cycle t when lookup_en, outputs valid at t+1.
  - Outputs hold while lookup_en=0.
  - lookup_match[i] = valid[i] & (tag[i]==sampled tag).
- Update (slot i, when update_en[i] and state!=INIT):
  - Entry written iff provider[i] | alloc[i]. alloc takes priority.
  - alloc writes valid=1, tag=update_tag, u=0, and ctr = real_taken ? 1<<(CTR_WIDTH-1) : (1<<(CTR_WIDTH-1))-1.
  - provider writes ctr = origin_ctr ±1 toward real_taken, saturating at 0 and 2^CTR_WIDTH-1. Tag is rewritten; valid is unchanged.
  - u is written with update_u iff update_u_en[i] & ~alloc[i].
- Tick:
  - alloc_fail increments tick (saturating); alloc_ok decrements it (floor 0).
  - Both asserted: no change.
  - When tick would reach 2^TICK_WIDTH-1 in IDLE, go to AGING, tick:=0, ptr:=0.
  - Tick is frozen in AGING and INIT.
- AGING:
  - aging_busy=1.
  - Each cycle, every slot's u at ptr becomes u>>1, then ptr++.
  - If any update writes u at index==ptr that cycle, the update wins and ptr holds. That entry is aged on the next cycle.
  - Returns to IDLE after aging ptr==DEPTH-1; aging_busy drops the same cycle the FSM enters IDLE.
  - Lookups and non-colliding updates proceed normally during AGING.
- Read/write on the same idx in the same cycle: the read returns pre-write data unless TAGE_TABLE_BYPASS_EN is defined.

Optional Feature:
- Macro: TAGE_TABLE_BYPASS_EN.
- Defined: a sampled lookup whose idx equals the same-cycle written idx returns the written slot fields (written-first), per slot being written. Unwritten slots return stored data.
- Undefined: the read returns old data; no forwarding logic.

Test Plan:
- DEPTH=16, pulse rst one cycle → ready=0 for 16 cycles, then 1. Lookup idx 3, tag 0x00 → lookup_match=00.
- Alloc slot0 at idx 5, tag 0x3A, real_taken=1, then lookup idx 5 tag 0x3A → match=01, ctr0=3'b100, u0=0, taken0=1. Same flow with real_taken=0 → ctr0=3'b011.
- Provider update, origin_ctr=3'b111, real_taken=1 → stored 3'b111. origin_ctr=3'b000, real_taken=0 → 3'b000. origin_ctr=3'b011, real_taken=1 → 3'b100.
- TICK_WIDTH=3, DEPTH=16, u at idx 2 = 3: seven alloc_fail pulses → aging_busy=1 for 16 cycles. idx 2 u → 1, tick reads 0 afterwards.
- During AGING at ptr=4, update_u_en writes u=3 to idx 4 → update written, ptr holds one cycle, final u=1. Assert rst mid-sweep → INIT, ready=0, aging_busy=0.
- Same-cycle alloc and lookup at idx 7, tag 0x11 → next-cycle match0=1 with TAGE_TABLE_BYPASS_EN defined, 0 without.

Source files
------------

// File: rtl/tage_tagged_table_v2_if.sv
// Bundle of lookup, update, tick and status signals between the TAGE top
// (master) and one tagged component table (slave).
interface tage_tagged_table_v2_if #(
  parameter int SLOT_NUM   = 2,
  parameter int ADDR_WIDTH = 11,
  parameter int TAG_WIDTH  = 8,
  parameter int CTR_WIDTH  = 3,
  parameter int U_WIDTH    = 2
) ();

  // Lookup request and registered response
  logic                          lookup_en;
  logic [ADDR_WIDTH-1:0]         lookup_idx;
  logic [TAG_WIDTH-1:0]          lookup_tag;
  logic [SLOT_NUM-1:0]           lookup_match;
  logic [SLOT_NUM*CTR_WIDTH-1:0] lookup_ctr;
  logic [SLOT_NUM*U_WIDTH-1:0]   lookup_u;
  logic [SLOT_NUM-1:0]           taken;

  // Per-slot update request
  logic [ADDR_WIDTH-1:0]         update_idx;
  logic [TAG_WIDTH-1:0]          update_tag;
  logic [SLOT_NUM-1:0]           update_en;
  logic [SLOT_NUM-1:0]           provider;
  logic [SLOT_NUM-1:0]           alloc;
  logic [SLOT_NUM-1:0]           real_taken;
  logic [SLOT_NUM*CTR_WIDTH-1:0] origin_ctr;
  logic [SLOT_NUM-1:0]           update_u_en;
  logic [SLOT_NUM*U_WIDTH-1:0]   update_u;

  // Global allocation outcome driving the aging tick
  logic                          alloc_fail;
  logic                          alloc_ok;

  // Status
  logic                          ready;
  logic                          aging_busy;

  modport master (
    output lookup_en, lookup_idx, lookup_tag,
    output update_idx, update_tag, update_en, provider, alloc, real_taken,
    output origin_ctr, update_u_en, update_u, alloc_fail, alloc_ok,
    input  lookup_match, lookup_ctr, lookup_u, taken, ready, aging_busy
  );

  modport slave (
    input  lookup_en, lookup_idx, lookup_tag,
    input  update_idx, update_tag, update_en, provider, alloc, real_taken,
    input  origin_ctr, update_u_en, update_u, alloc_fail, alloc_ok,
    output lookup_match, lookup_ctr, lookup_u, taken, ready, aging_busy
  );

endinterface

// File: rtl/tage_tagged_table_v2.sv
// Tagged TAGE component table: SLOT_NUM slots per entry, DEPTH entries.
// Each slot entry holds {valid, tag, ctr, u}. {tag, ctr} live in RAM-mappable
// arrays written through one port; valid and u are flops so that provider
// updates keep valid and the aging sweep can run beside normal updates.
// A hardware sweep clears the table after reset (INIT) and a tick-driven
// sweep halves every useful counter (AGING).
// Optional build macro: TAGE_TABLE_BYPASS_EN -- a lookup sampled in the same
// cycle as an update to the same index sees the newly written slot fields.
module tage_tagged_table_v2 #(
  parameter int SLOT_NUM   = 2,
  parameter int DEPTH      = 2048,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int TAG_WIDTH  = 8,
  parameter int CTR_WIDTH  = 3,
  parameter int U_WIDTH    = 2,
  parameter int TICK_WIDTH = 7
) (
  input logic                   clk,
  input logic                   rst,
  tage_tagged_table_v2_if.slave tbl
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX    = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [TICK_WIDTH-1:0] TICK_ARM    = {{(TICK_WIDTH-1){1'b1}}, 1'b0};
  localparam logic [CTR_WIDTH-1:0]  CTR_MAX     = '1;
  localparam logic [CTR_WIDTH-1:0]  CTR_WEAK_T  = {1'b1, {(CTR_WIDTH-1){1'b0}}};
  localparam logic [CTR_WIDTH-1:0]  CTR_WEAK_NT = {1'b0, {(CTR_WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_AGING = 2'd2
  } state_e;

  state_e                 state;
  logic [ADDR_WIDTH-1:0]  ptr;
  logic [TICK_WIDTH-1:0]  tick;
  logic                   ready_q;
  logic                   aging_busy_q;

  // Storage
  logic [DEPTH-1:0]       valid_arr [SLOT_NUM];
  logic [TAG_WIDTH-1:0]   tag_mem   [SLOT_NUM][DEPTH];
  logic [CTR_WIDTH-1:0]   ctr_mem   [SLOT_NUM][DEPTH];
  logic [U_WIDTH-1:0]     u_arr     [SLOT_NUM][DEPTH];

  // Update decode
  logic [SLOT_NUM-1:0]    upd_act;
  logic [SLOT_NUM-1:0]    ent_we;
  logic [SLOT_NUM-1:0]    u_we;
  logic [CTR_WIDTH-1:0]   wr_ctr [SLOT_NUM];
  logic [U_WIDTH-1:0]     wr_u   [SLOT_NUM];
  logic [CTR_WIDTH-1:0]   org_ctr;

  // Sweep and tick control
  logic                   init_clr;
  logic                   age_hit;
  logic                   age_en;
  logic                   tick_up;
  logic                   tick_dn;

  // Lookup read path and registered outputs
  logic [SLOT_NUM-1:0]           rd_valid;
  logic [TAG_WIDTH-1:0]          rd_tag [SLOT_NUM];
  logic [SLOT_NUM*CTR_WIDTH-1:0] rd_ctr;
  logic [SLOT_NUM*U_WIDTH-1:0]   rd_u;
  logic [SLOT_NUM-1:0]           rd_hit;
  logic [SLOT_NUM-1:0]           out_match;
  logic [SLOT_NUM*CTR_WIDTH-1:0] out_ctr;
  logic [SLOT_NUM*U_WIDTH-1:0]   out_u;

  // Per-slot write enables and write data for the incoming update
  // NOTE: combinational blocks use blocking '=' and give every output a value
  // on every path, so no latch is inferred; clocked blocks use '<=' only.
  always_comb begin
    org_ctr = '0;
    for (int i = 0; i < SLOT_NUM; i++) begin
      org_ctr    = tbl.origin_ctr[i*CTR_WIDTH +: CTR_WIDTH];
      upd_act[i] = ~rst & (state != ST_INIT) & tbl.update_en[i];
      ent_we[i]  = upd_act[i] & (tbl.provider[i] | tbl.alloc[i]);
      u_we[i]    = upd_act[i] & (tbl.alloc[i] | tbl.update_u_en[i]);
      if (tbl.alloc[i]) begin
        wr_ctr[i] = tbl.real_taken[i] ? CTR_WEAK_T : CTR_WEAK_NT;
      end else if (tbl.real_taken[i]) begin
        wr_ctr[i] = (org_ctr == CTR_MAX) ? org_ctr : org_ctr + 1'b1;
      end else begin
        wr_ctr[i] = (org_ctr == '0) ? org_ctr : org_ctr - 1'b1;
      end
      wr_u[i] = tbl.alloc[i] ? '0 : tbl.update_u[i*U_WIDTH +: U_WIDTH];
    end
  end

  // An update writing u at the aging pointer wins; the sweep retries next cycle
  assign init_clr = ~rst & (state == ST_INIT);
  assign age_hit  = (|u_we) & (tbl.update_idx == ptr);
  assign age_en   = ~rst & (state == ST_AGING) & ~age_hit;
  assign tick_up  = tbl.alloc_fail & ~tbl.alloc_ok;
  assign tick_dn  = tbl.alloc_ok & ~tbl.alloc_fail;

  // Control FSM: init sweep, idle with tick tracking, aging sweep
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_INIT;
      ptr          <= '0;
      tick         <= '0;
      ready_q      <= 1'b0;
      aging_busy_q <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          ptr <= ptr + 1'b1;
          if (ptr == LAST_IDX) begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (tick_up) begin
            // Reaching the saturation value launches the sweep instead
            if (tick == TICK_ARM) begin
              state        <= ST_AGING;
              tick         <= '0;
              ptr          <= '0;
              aging_busy_q <= 1'b1;
            end else begin
              tick <= tick + 1'b1;
            end
          end else if (tick_dn && (tick != '0)) begin
            tick <= tick - 1'b1;
          end
        end
        ST_AGING: begin
          if (!age_hit) begin
            ptr <= ptr + 1'b1;
            if (ptr == LAST_IDX) begin
              state        <= ST_IDLE;
              aging_busy_q <= 1'b0;
            end
          end
        end
        default: begin
          state <= ST_INIT;
          ptr   <= '0;
        end
      endcase
    end
  end

  // Tag and counter arrays: single write port shared by init clear and updates
  // NOTE: the storage arrays have no reset branch; the INIT sweep clears them
  // entry by entry, which keeps them mappable to RAM and avoids a huge reset fan-out.
  always_ff @(posedge clk) begin
    for (int i = 0; i < SLOT_NUM; i++) begin
      if (init_clr) begin
        ctr_mem[i][ptr] <= '0;
      end else if (ent_we[i]) begin
        tag_mem[i][tbl.update_idx] <= tbl.update_tag;
        ctr_mem[i][tbl.update_idx] <= wr_ctr[i];
      end
    end
  end

  // Valid bits: cleared by the init sweep, set only by allocation
  always_ff @(posedge clk) begin
    for (int i = 0; i < SLOT_NUM; i++) begin
      if (init_clr) begin
        valid_arr[i][ptr] <= 1'b0;
      end else if (ent_we[i] && tbl.alloc[i]) begin
        valid_arr[i][tbl.update_idx] <= 1'b1;
      end
    end
  end

  // Useful counters: init clear, aging halving at ptr, update writes
  always_ff @(posedge clk) begin
    for (int i = 0; i < SLOT_NUM; i++) begin
      if (init_clr) begin
        u_arr[i][ptr] <= '0;
      end else begin
        if (age_en) begin
          u_arr[i][ptr] <= u_arr[i][ptr] >> 1;
        end
        if (u_we[i]) begin
          u_arr[i][tbl.update_idx] <= wr_u[i];
        end
      end
    end
  end

  // Lookup read of the addressed set, with optional write-first forwarding
  always_comb begin
    for (int i = 0; i < SLOT_NUM; i++) begin
      rd_valid[i]                        = valid_arr[i][tbl.lookup_idx];
      rd_tag[i]                          = tag_mem[i][tbl.lookup_idx];
      rd_ctr[i*CTR_WIDTH +: CTR_WIDTH]   = ctr_mem[i][tbl.lookup_idx];
      rd_u[i*U_WIDTH +: U_WIDTH]         = u_arr[i][tbl.lookup_idx];
`ifdef TAGE_TABLE_BYPASS_EN
      if (tbl.lookup_idx == tbl.update_idx) begin
        if (ent_we[i]) begin
          rd_valid[i]                      = rd_valid[i] | tbl.alloc[i];
          rd_tag[i]                        = tbl.update_tag;
          rd_ctr[i*CTR_WIDTH +: CTR_WIDTH] = wr_ctr[i];
        end
        if (u_we[i]) begin
          rd_u[i*U_WIDTH +: U_WIDTH] = wr_u[i];
        end
      end
`endif
      rd_hit[i] = rd_valid[i] & (rd_tag[i] == tbl.lookup_tag);
    end
  end

  // Lookup response registers: load on lookup_en, hold otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      out_match <= '0;
      out_ctr   <= '0;
      out_u     <= '0;
    end else begin
      if (tbl.lookup_en) begin
        out_ctr <= rd_ctr;
        out_u   <= rd_u;
      end
      if (state == ST_INIT) begin
        out_match <= '0;
      end else if (tbl.lookup_en) begin
        out_match <= rd_hit;
      end
    end
  end

  // Predicted direction is the counter MSB of each slot
  always_comb begin
    tbl.taken = '0;
    for (int i = 0; i < SLOT_NUM; i++) begin
      tbl.taken[i] = out_ctr[i*CTR_WIDTH + CTR_WIDTH - 1];
    end
  end

  assign tbl.lookup_match = out_match;
  assign tbl.lookup_ctr   = out_ctr;
  assign tbl.lookup_u     = out_u;
  assign tbl.ready        = ready_q;
  assign tbl.aging_busy   = aging_busy_q;

endmodule

// File: tb/tb_tage_tagged_table_v2.sv
// Directed bench for tage_tagged_table_v2 with DEPTH=16 and TICK_WIDTH=3.
module tb_tage_tagged_table_v2;

  localparam int SLOT_NUM   = 2;
  localparam int DEPTH      = 16;
  localparam int ADDR_WIDTH = 4;
  localparam int TAG_WIDTH  = 8;
  localparam int CTR_WIDTH  = 3;
  localparam int U_WIDTH    = 2;
  localparam int TICK_WIDTH = 3;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  tage_tagged_table_v2_if #(
    .SLOT_NUM(SLOT_NUM), .ADDR_WIDTH(ADDR_WIDTH), .TAG_WIDTH(TAG_WIDTH),
    .CTR_WIDTH(CTR_WIDTH), .U_WIDTH(U_WIDTH)
  ) bus ();

  tage_tagged_table_v2 #(
    .SLOT_NUM(SLOT_NUM), .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH),
    .TAG_WIDTH(TAG_WIDTH), .CTR_WIDTH(CTR_WIDTH), .U_WIDTH(U_WIDTH),
    .TICK_WIDTH(TICK_WIDTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .tbl (bus)
  );

  // Advance one clock; outputs are observed 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_update();
    bus.update_idx  = '0;
    bus.update_tag  = '0;
    bus.update_en   = '0;
    bus.provider    = '0;
    bus.alloc       = '0;
    bus.real_taken  = '0;
    bus.origin_ctr  = '0;
    bus.update_u_en = '0;
    bus.update_u    = '0;
  endtask

  task automatic clear_inputs();
    bus.lookup_en  = 1'b0;
    bus.lookup_idx = '0;
    bus.lookup_tag = '0;
    bus.alloc_fail = 1'b0;
    bus.alloc_ok   = 1'b0;
    clear_update();
  endtask

  task automatic lookup(input logic [3:0] idx, input logic [7:0] tag);
    bus.lookup_en  = 1'b1;
    bus.lookup_idx = idx;
    bus.lookup_tag = tag;
    step();
    bus.lookup_en  = 1'b0;
  endtask

  task automatic update(input logic [3:0] idx, input logic [7:0] tag,
                        input logic [1:0] en, input logic [1:0] prov,
                        input logic [1:0] al, input logic [1:0] rt,
                        input logic [5:0] octr, input logic [1:0] uen,
                        input logic [3:0] uval);
    bus.update_idx  = idx;
    bus.update_tag  = tag;
    bus.update_en   = en;
    bus.provider    = prov;
    bus.alloc       = al;
    bus.real_taken  = rt;
    bus.origin_ctr  = octr;
    bus.update_u_en = uen;
    bus.update_u    = uval;
    step();
    clear_update();
  endtask

  task automatic pulse_tick(input logic fail, input logic ok);
    bus.alloc_fail = fail;
    bus.alloc_ok   = ok;
    step();
    bus.alloc_fail = 1'b0;
    bus.alloc_ok   = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b exp 0", bus.ready); end
    checks++; if (bus.aging_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b exp 0", bus.aging_busy); end
    checks++; if (bus.lookup_match !== 2'b00) begin errors++; $display("FAIL rst_match: got %b exp 00", bus.lookup_match); end
    checks++; if (bus.lookup_ctr !== 6'b0) begin errors++; $display("FAIL rst_ctr: got %b exp 0", bus.lookup_ctr); end
    checks++; if (bus.lookup_u !== 4'b0) begin errors++; $display("FAIL rst_u: got %b exp 0", bus.lookup_u); end
    checks++; if (bus.taken !== 2'b00) begin errors++; $display("FAIL rst_taken: got %b exp 00", bus.taken); end
    for (int k = 1; k < DEPTH; k++) begin
      step();
      checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL init_ready_low cyc%0d: got %b exp 0", k, bus.ready); end
    end
    step();
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL init_ready_high: got %b exp 1", bus.ready); end
    lookup(4'd3, 8'h00);
    checks++; if (bus.lookup_match !== 2'b00) begin errors++; $display("FAIL init_lookup_match: got %b exp 00", bus.lookup_match); end
  endtask

  task automatic test_alloc();
    update(4'd5, 8'h3A, 2'b01, 2'b00, 2'b01, 2'b01, 6'b0, 2'b00, 4'b0);
    lookup(4'd5, 8'h3A);
    checks++; if (bus.lookup_match !== 2'b01) begin errors++; $display("FAIL alloc_t_match: got %b exp 01", bus.lookup_match); end
    checks++; if (bus.lookup_ctr[2:0] !== 3'b100) begin errors++; $display("FAIL alloc_t_ctr: got %b exp 100", bus.lookup_ctr[2:0]); end
    checks++; if (bus.lookup_u[1:0] !== 2'b00) begin errors++; $display("FAIL alloc_t_u: got %b exp 00", bus.lookup_u[1:0]); end
    checks++; if (bus.taken !== 2'b01) begin errors++; $display("FAIL alloc_t_taken: got %b exp 01", bus.taken); end
    update(4'd6, 8'h3A, 2'b01, 2'b00, 2'b01, 2'b00, 6'b0, 2'b00, 4'b0);
    lookup(4'd6, 8'h3A);
    checks++; if (bus.lookup_match !== 2'b01) begin errors++; $display("FAIL alloc_nt_match: got %b exp 01", bus.lookup_match); end
    checks++; if (bus.lookup_ctr[2:0] !== 3'b011) begin errors++; $display("FAIL alloc_nt_ctr: got %b exp 011", bus.lookup_ctr[2:0]); end
    checks++; if (bus.taken !== 2'b00) begin errors++; $display("FAIL alloc_nt_taken: got %b exp 00", bus.taken); end
    update(4'd5, 8'h3A, 2'b10, 2'b00, 2'b10, 2'b10, 6'b0, 2'b00, 4'b0);
    lookup(4'd5, 8'h3A);
    checks++; if (bus.lookup_match !== 2'b11) begin errors++; $display("FAIL alloc_s1_match: got %b exp 11", bus.lookup_match); end
    checks++; if (bus.lookup_ctr !== 6'b100100) begin errors++; $display("FAIL alloc_s1_ctr: got %b exp 100100", bus.lookup_ctr); end
    lookup(4'd5, 8'h3B);
    checks++; if (bus.lookup_match !== 2'b00) begin errors++; $display("FAIL tag_miss_match: got %b exp 00", bus.lookup_match); end
  endtask

  task automatic test_provider();
    update(4'd5, 8'h3A, 2'b01, 2'b01, 2'b00, 2'b01, 6'b000111, 2'b00, 4'b0);
    lookup(4'd5, 8'h3A);
    checks++; if (bus.lookup_ctr[2:0] !== 3'b111) begin errors++; $display("FAIL prov_sat_hi: got %b exp 111", bus.lookup_ctr[2:0]); end
    checks++; if (bus.lookup_match !== 2'b11) begin errors++; $display("FAIL prov_keep_valid: got %b exp 11", bus.lookup_match); end
    update(4'd5, 8'h3A, 2'b01, 2'b01, 2'b00, 2'b00, 6'b000000, 2'b00, 4'b0);
    lookup(4'd5, 8'h3A);
    checks++; if (bus.lookup_ctr[2:0] !== 3'b000) begin errors++; $display("FAIL prov_sat_lo: got %b exp 000", bus.lookup_ctr[2:0]); end
    update(4'd5, 8'h3A, 2'b01, 2'b01, 2'b00, 2'b01, 6'b000011, 2'b01, 4'b0011);
    lookup(4'd5, 8'h3A);
    checks++; if (bus.lookup_ctr[2:0] !== 3'b100) begin errors++; $display("FAIL prov_inc: got %b exp 100", bus.lookup_ctr[2:0]); end
    checks++; if (bus.lookup_u[1:0] !== 2'b11) begin errors++; $display("FAIL prov_u_write: got %b exp 11", bus.lookup_u[1:0]); end
    // Provider on an invalid entry writes ctr but leaves valid clear
    update(4'd9, 8'h22, 2'b01, 2'b01, 2'b00, 2'b00, 6'b000010, 2'b00, 4'b0);
    lookup(4'd9, 8'h22);
    checks++; if (bus.lookup_match !== 2'b00) begin errors++; $display("FAIL prov_invalid_match: got %b exp 00", bus.lookup_match); end
    checks++; if (bus.lookup_ctr[2:0] !== 3'b001) begin errors++; $display("FAIL prov_dec: got %b exp 001", bus.lookup_ctr[2:0]); end
    // Alloc beats provider and blocks the u write
    update(4'd10, 8'h44, 2'b01, 2'b01, 2'b01, 2'b00, 6'b000111, 2'b01, 4'b0011);
    lookup(4'd10, 8'h44);
    checks++; if (bus.lookup_match !== 2'b01) begin errors++; $display("FAIL prio_match: got %b exp 01", bus.lookup_match); end
    checks++; if (bus.lookup_ctr[2:0] !== 3'b011) begin errors++; $display("FAIL prio_ctr: got %b exp 011", bus.lookup_ctr[2:0]); end
    checks++; if (bus.lookup_u[1:0] !== 2'b00) begin errors++; $display("FAIL prio_u: got %b exp 00", bus.lookup_u[1:0]); end
  endtask

  task automatic test_aging();
    int busy_cycles;
    update(4'd2, 8'h00, 2'b01, 2'b00, 2'b00, 2'b00, 6'b0, 2'b01, 4'b0011);
    lookup(4'd2, 8'h00);
    checks++; if (bus.lookup_u[1:0] !== 2'b11) begin errors++; $display("FAIL u_only_write: got %b exp 11", bus.lookup_u[1:0]); end
    checks++; if (bus.lookup_match !== 2'b00) begin errors++; $display("FAIL u_only_no_entry: got %b exp 00", bus.lookup_match); end
    for (int k = 0; k < 6; k++) pulse_tick(1'b1, 1'b0);
    checks++; if (bus.aging_busy !== 1'b0) begin errors++; $display("FAIL tick6_busy: got %b exp 0", bus.aging_busy); end
    pulse_tick(1'b1, 1'b0);
    checks++; if (bus.aging_busy !== 1'b1) begin errors++; $display("FAIL tick7_busy: got %b exp 1", bus.aging_busy); end
    busy_cycles = 1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (bus.aging_busy !== 1'b1) break;
      busy_cycles++;
    end
    checks++; if (busy_cycles != DEPTH) begin errors++; $display("FAIL aging_len: got %0d exp %0d", busy_cycles, DEPTH); end
    lookup(4'd2, 8'h00);
    checks++; if (bus.lookup_u[1:0] !== 2'b01) begin errors++; $display("FAIL aged_idx2: got %b exp 01", bus.lookup_u[1:0]); end
    lookup(4'd5, 8'h3A);
    checks++; if (bus.lookup_u !== 4'b0001) begin errors++; $display("FAIL aged_idx5: got %b exp 0001", bus.lookup_u); end
    checks++; if (bus.lookup_match !== 2'b11) begin errors++; $display("FAIL aged_idx5_match: got %b exp 11", bus.lookup_match); end
  endtask

  task automatic test_tick_and_collision();
    int busy_cycles;
    // Tick trace: 0 (floor), 0 (both), 1..6, 6 (both), 5, 6, then sweep
    pulse_tick(1'b0, 1'b1);
    pulse_tick(1'b1, 1'b1);
    for (int k = 0; k < 6; k++) pulse_tick(1'b1, 1'b0);
    checks++; if (bus.aging_busy !== 1'b0) begin errors++; $display("FAIL tick_restart6: got %b exp 0", bus.aging_busy); end
    pulse_tick(1'b1, 1'b1);
    checks++; if (bus.aging_busy !== 1'b0) begin errors++; $display("FAIL tick_both: got %b exp 0", bus.aging_busy); end
    pulse_tick(1'b0, 1'b1);
    pulse_tick(1'b1, 1'b0);
    checks++; if (bus.aging_busy !== 1'b0) begin errors++; $display("FAIL tick_dec: got %b exp 0", bus.aging_busy); end
    pulse_tick(1'b1, 1'b0);
    checks++; if (bus.aging_busy !== 1'b1) begin errors++; $display("FAIL tick_second_sweep: got %b exp 1", bus.aging_busy); end
    busy_cycles = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      if (bus.aging_busy === 1'b1) busy_cycles++;
    end
    // ptr is 4 now: slot1 u write to idx 4 collides with the sweep
    update(4'd4, 8'h00, 2'b10, 2'b00, 2'b00, 2'b00, 6'b0, 2'b10, 4'b1100);
    if (bus.aging_busy === 1'b1) busy_cycles++;
    for (int k = 0; k < 40; k++) begin
      step();
      if (bus.aging_busy !== 1'b1) break;
      busy_cycles++;
    end
    checks++; if (busy_cycles != DEPTH + 1) begin errors++; $display("FAIL collide_len: got %0d exp %0d", busy_cycles, DEPTH + 1); end
    lookup(4'd4, 8'h00);
    checks++; if (bus.lookup_u !== 4'b0100) begin errors++; $display("FAIL collide_u: got %b exp 0100", bus.lookup_u); end
    lookup(4'd2, 8'h00);
    checks++; if (bus.lookup_u[1:0] !== 2'b00) begin errors++; $display("FAIL aged_twice: got %b exp 00", bus.lookup_u[1:0]); end
  endtask

  task automatic test_back_to_back();
    bus.lookup_en  = 1'b1;
    bus.lookup_idx = 4'd5;
    bus.lookup_tag = 8'h3A;
    step();
    checks++; if (bus.lookup_match !== 2'b11) begin errors++; $display("FAIL b2b_first_match: got %b exp 11", bus.lookup_match); end
    checks++; if (bus.lookup_ctr !== 6'b100100) begin errors++; $display("FAIL b2b_first_ctr: got %b exp 100100", bus.lookup_ctr); end
    bus.lookup_idx = 4'd6;
    step();
    checks++; if (bus.lookup_match !== 2'b01) begin errors++; $display("FAIL b2b_second_match: got %b exp 01", bus.lookup_match); end
    checks++; if (bus.lookup_ctr[2:0] !== 3'b011) begin errors++; $display("FAIL b2b_second_ctr: got %b exp 011", bus.lookup_ctr[2:0]); end
    bus.lookup_en  = 1'b0;
    bus.lookup_idx = 4'd5;
    step();
    checks++; if (bus.lookup_match !== 2'b01) begin errors++; $display("FAIL hold_match: got %b exp 01", bus.lookup_match); end
    checks++; if (bus.lookup_ctr[2:0] !== 3'b011) begin errors++; $display("FAIL hold_ctr: got %b exp 011", bus.lookup_ctr[2:0]); end
  endtask

  task automatic test_bypass();
    logic [1:0] exp_match;
    logic [2:0] exp_ctr;
`ifdef TAGE_TABLE_BYPASS_EN
    exp_match = 2'b01;
    exp_ctr   = 3'b100;
`else
    exp_match = 2'b00;
    exp_ctr   = 3'b000;
`endif
    bus.lookup_en  = 1'b1;
    bus.lookup_idx = 4'd7;
    bus.lookup_tag = 8'h11;
    update(4'd7, 8'h11, 2'b01, 2'b00, 2'b01, 2'b01, 6'b0, 2'b00, 4'b0);
    bus.lookup_en  = 1'b0;
    checks++; if (bus.lookup_match !== exp_match) begin errors++; $display("FAIL same_cycle_match: got %b exp %b", bus.lookup_match, exp_match); end
    checks++; if (bus.lookup_ctr[2:0] !== exp_ctr) begin errors++; $display("FAIL same_cycle_ctr: got %b exp %b", bus.lookup_ctr[2:0], exp_ctr); end
    lookup(4'd7, 8'h11);
    checks++; if (bus.lookup_match !== 2'b01) begin errors++; $display("FAIL after_write_match: got %b exp 01", bus.lookup_match); end
    checks++; if (bus.lookup_ctr[2:0] !== 3'b100) begin errors++; $display("FAIL after_write_ctr: got %b exp 100", bus.lookup_ctr[2:0]); end
  endtask

  task automatic test_reset_mid_aging();
    int wait_cycles;
    for (int k = 0; k < 7; k++) pulse_tick(1'b1, 1'b0);
    checks++; if (bus.aging_busy !== 1'b1) begin errors++; $display("FAIL third_sweep_busy: got %b exp 1", bus.aging_busy); end
    for (int k = 0; k < 3; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b exp 0", bus.ready); end
    checks++; if (bus.aging_busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b exp 0", bus.aging_busy); end
    checks++; if (bus.lookup_match !== 2'b00) begin errors++; $display("FAIL mid_rst_match: got %b exp 00", bus.lookup_match); end
    wait_cycles = 0;
    while (bus.ready !== 1'b1 && wait_cycles < 40) begin
      step();
      wait_cycles++;
    end
    checks++; if (wait_cycles != DEPTH) begin errors++; $display("FAIL mid_rst_init_len: got %0d exp %0d", wait_cycles, DEPTH); end
    lookup(4'd5, 8'h3A);
    checks++; if (bus.lookup_match !== 2'b00) begin errors++; $display("FAIL cleared_match: got %b exp 00", bus.lookup_match); end
    checks++; if (bus.lookup_ctr !== 6'b0) begin errors++; $display("FAIL cleared_ctr: got %b exp 0", bus.lookup_ctr); end
    checks++; if (bus.lookup_u !== 4'b0) begin errors++; $display("FAIL cleared_u: got %b exp 0", bus.lookup_u); end
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_provider();
    test_aging();
    test_tick_and_collision();
    test_back_to_back();
    test_bypass();
    test_reset_mid_aging();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
